// File: rtl/jtag_tap_target.sv
// IEEE 1149.1 TAP target: 16-state controller, instruction register and
// bypass / user / boundary-scan data registers behind a single TDO.
module jtag_tap_target #(
  parameter int IR_WIDTH  = 5,
  parameter int DR_WIDTH  = 8,
  parameter int BSR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic [3:0]           tap_state,
  output logic [IR_WIDTH-1:0]  ir_value,
  input  logic [DR_WIDTH-1:0]  user_capture_data,
  output logic [DR_WIDTH-1:0]  user_update_data,
  output logic                 user_update_pulse,
  input  logic [BSR_WIDTH-1:0] bsr_capture_data,
  output logic [BSR_WIDTH-1:0] bsr_update_data,
  output logic                 bsr_update_pulse
);

  localparam logic [3:0] TLR    = 4'd0,  IDLE   = 4'd1,  SEL_DR = 4'd2,  SEL_IR = 4'd3;
  localparam logic [3:0] CAP_IR = 4'd4,  SH_IR  = 4'd5,  EX1_IR = 4'd6,  PAU_IR = 4'd7;
  localparam logic [3:0] EX2_IR = 4'd8,  UPD_IR = 4'd9,  CAP_DR = 4'd10, SH_DR  = 4'd11;
  localparam logic [3:0] EX1_DR = 4'd12, PAU_DR = 4'd13, EX2_DR = 4'd14, UPD_DR = 4'd15;

  localparam logic [4:0] OP_USER = 5'b00001;
  localparam logic [4:0] OP_BSR  = 5'b00110;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic [3:0]           state_q, state_d;
  logic [IR_WIDTH-1:0]  ir_shift_q, ir_shift_d, ir_value_q, ir_value_d;
  logic [DR_WIDTH-1:0]  user_sh_q, user_sh_d, user_upd_q, user_upd_d;
  logic [BSR_WIDTH-1:0] bsr_sh_q, bsr_sh_d, bsr_upd_q, bsr_upd_d;
  logic                 byp_q, byp_d;
  logic                 user_pulse_q, user_pulse_d, bsr_pulse_q, bsr_pulse_d;
  logic                 sel_user, sel_bsr;

  // Opcodes compare on their low IR_WIDTH bits so narrow IRs alias cleanly.
  assign sel_user = (ir_value_q == OP_USER[IR_WIDTH-1:0]);
  assign sel_bsr  = (ir_value_q == OP_BSR[IR_WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : IDLE;
      IDLE:   state_d = tms ? SEL_DR : IDLE;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : IDLE;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : IDLE;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    ir_shift_d   = ir_shift_q;
    ir_value_d   = ir_value_q;
    user_sh_d    = user_sh_q;
    bsr_sh_d     = bsr_sh_q;
    byp_d        = byp_q;
    user_upd_d   = user_upd_q;
    bsr_upd_d    = bsr_upd_q;
    user_pulse_d = 1'b0;
    bsr_pulse_d  = 1'b0;
    case (state_q)
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR:  ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
      UPD_IR: ir_value_d = ir_shift_q;
      CAP_DR: begin
        if (sel_user)     user_sh_d = user_capture_data;
        else if (sel_bsr) bsr_sh_d  = bsr_capture_data;
        else              byp_d     = 1'b0;
      end
      SH_DR: begin
        if (sel_user)     user_sh_d = {tdi, user_sh_q[DR_WIDTH-1:1]};
        else if (sel_bsr) bsr_sh_d  = {tdi, bsr_sh_q[BSR_WIDTH-1:1]};
        else              byp_d     = tdi;
      end
      UPD_DR: begin
        if (sel_user) begin
          user_upd_d   = user_sh_q;
          user_pulse_d = 1'b1;
        end else if (sel_bsr) begin
          bsr_upd_d   = bsr_sh_q;
          bsr_pulse_d = 1'b1;
        end
      end
      default: ;
    endcase
    // Test-Logic-Reset always forces the bypass instruction.
    if (state_d == TLR) ir_value_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TLR;
      ir_shift_q   <= '0;
      ir_value_q   <= '0;
      user_sh_q    <= '0;
      bsr_sh_q     <= '0;
      byp_q        <= 1'b0;
      user_upd_q   <= '0;
      bsr_upd_q    <= '0;
      user_pulse_q <= 1'b0;
      bsr_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_shift_q   <= ir_shift_d;
      ir_value_q   <= ir_value_d;
      user_sh_q    <= user_sh_d;
      bsr_sh_q     <= bsr_sh_d;
      byp_q        <= byp_d;
      user_upd_q   <= user_upd_d;
      bsr_upd_q    <= bsr_upd_d;
      user_pulse_q <= user_pulse_d;
      bsr_pulse_q  <= bsr_pulse_d;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == SH_IR)      tdo = ir_shift_q[0];
    else if (state_q == SH_DR) tdo = sel_user ? user_sh_q[0] : (sel_bsr ? bsr_sh_q[0] : byp_q);
  end

  assign tdo_en            = (state_q == SH_IR) || (state_q == SH_DR);
  assign tap_state         = state_q;
  assign ir_value          = ir_value_q;
  assign user_update_data  = user_upd_q;
  assign user_update_pulse = user_pulse_q;
  assign bsr_update_data   = bsr_upd_q;
  assign bsr_update_pulse  = bsr_pulse_q;

endmodule

// File: doc/jtag_tap_target.md
Name: jtag_tap_target

Overview:
- Synthesizable JTAG target device (DUT side) that consumes the TMS/TDI streams driven by the JTAG AVIP master agent and returns TDO.
- Implements the 16-state IEEE 1149.1 TAP controller and an instruction register of 3–5 bits.
- Data registers: 1-bit bypass, user-defined DR and boundary-scan DR, selected by the opcodes of the global package (bypass 5'b00000, user 5'b00001, boundary 5'b00110).
- Serves as the reference target for the slave agent and the scoreboard.

Parameters:
- IR_WIDTH, 5, instruction register width; legal 3, 4, 5. Opcodes are compared on their low IR_WIDTH bits.
- DR_WIDTH, 8, user-defined register width; legal 8, 16, 24, 32.
- BSR_WIDTH, 32, boundary-scan register width; legal 8..62.

Ports:
- clk, input, 1, TCK; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high.
- tms, input, 1, test mode select.
- tdi, input, 1, test data in.
- tdo, output, 1, test data out.
- tdo_en, output, 1, high while in ShiftIr or ShiftDr.
- tap_state, output, 4, current state; encoding = JtagTapStates index (Reset=0, Idle=1, DrScan=2, IrScan=3, CaptureIr=4 … UpdateDr=15).
- ir_value, output, IR_WIDTH, active instruction.
- user_capture_data, input, DR_WIDTH, parallel value loaded in CaptureDr when user is selected.
- user_update_data, output, DR_WIDTH, user register latched in UpdateDr.
- user_update_pulse, output, 1, one-cycle strobe on user update.
- bsr_capture_data, input, BSR_WIDTH, boundary capture value.
- bsr_update_data, output, BSR_WIDTH, boundary register latched in UpdateDr.
- bsr_update_pulse, output, 1, one-cycle strobe on boundary update.

Behaviour:
- Reset (synchronous, active-high), effective at the next edge: tap_state=0, ir_value=0 (bypass), all shift registers=0, update_data outputs=0, pulses=0.
  - tdo=0 and tdo_en=0 whenever the state is not a Shift state.
  - Reset asserted mid-operation aborts any shift. No update occurs.
- FSM: standard 1149.1 transition on tms at each edge. Pairs are (tms=0 → , tms=1 →):
  - Reset: Idle, Reset
  - Idle: Idle, DrScan
  - DrScan: CaptureDr, IrScan
  - IrScan: CaptureIr, Reset
  - Capture*: Shift*, Exit1*
  - Shift*: Shift*, Exit1*
  - Exit1*: Pause*, Update*
  - Pause*: Pause*, Exit2*
  - Exit2*: Shift*, Update*
  - Update*: Idle, DrScan
  - Five consecutive tms=1 reach Reset from any state.
- Entering Reset via TMS loads ir_value=0. update_data outputs are unchanged.
- IR path:
  - Edge leaving CaptureIr: ir_shift = {zeros, 2'b01}.
  - Each edge while in ShiftIr: ir_shift = {tdi, ir_shift[IR_WIDTH-1:1]}. This includes the edge that exits to Exit1Ir.
  - Edge leaving UpdateIr: ir_value = ir_shift.
  - Pause and Exit states hold contents.
- DR select, decoded from ir_value: user opcode → user DR; boundary opcode → BSR; anything else (including bypass) → 1-bit bypass.
- DR path:
  - CaptureDr loads the selected register: user_capture_data, bsr_capture_data, or 0 for bypass.
  - ShiftDr shifts right with tdi entering the MSB.
  - Edge leaving UpdateDr: the selected register is copied to its update_data output, and its update_pulse is high for exactly one cycle, in the cycle following UpdateDr.
  - Bypass produces no update pulse.
- tdo: combinational from registers only, with no path from tdi or tms. Equals bit 0 of the active shift register while in a Shift state, else 0. The first bit out is capture bit 0.
- Latency: bit k shifted in appears on tdo W cycles later, where W is the active register length (1 for bypass).

Test Plan:
- Reset held 2 cycles from arbitrary state → tap_state=0, ir_value=0, tdo_en=0, update outputs 0. Then from ShiftDr, tms=1×5 → tap_state=0.
- IR load, IR_WIDTH=5: tms 0,1,1,0,0 reaches ShiftIr; shift tdi 1,0,0,0,0 with tms=1 on the last bit; then tms 1,0 → tdo emits 1,0,0,0,0 and ir_value=5'b00001 after UpdateIr.
- User DR, DR_WIDTH=8, user_capture_data=8'hA5: shift in 8'h3C LSB-first → tdo 1,0,1,0,0,1,0,1; user_update_data=8'h3C; user_update_pulse high exactly 1 cycle.
- Bypass: ir_value=0; shift tdi 1,0,1,1,0,0,1,0 → tdo 0,1,0,1,1,0,0,1 (one-cycle delay, leading 0). No update pulse.
- Pause resume plus unknown opcode: ir_value=5'b00101 selects bypass. User DR with detour ShiftDr→Exit1→Pause(3 cycles)→Exit2→ShiftDr → shifted result identical to the uninterrupted shift.
- Reset mid-ShiftDr after 4 of 8 bits → tap_state=0 next cycle, no user_update_pulse, user_update_data unchanged at 0.
